// File: rtl/psram_xfer_arb.sv
// N-channel transaction arbiter in front of psram_core: round-robin or fixed-priority grant,
// single outstanding transaction, per-transaction timeout with error response.
module psram_xfer_arb #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TMO_WIDTH  = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              cfg_en_i,
  input  logic                              cfg_prio_i,
  input  logic [TMO_WIDTH-1:0]              cfg_tmo_i,
  input  logic [NUM_CH-1:0]                 req_valid_i,
  output logic [NUM_CH-1:0]                 req_ready_o,
  input  logic [NUM_CH-1:0]                 req_rdwr_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]      req_wdata_i,
  input  logic [NUM_CH*(DATA_WIDTH/8)-1:0]  req_mask_i,
  output logic [NUM_CH-1:0]                 rsp_valid_o,
  output logic                              rsp_err_o,
  output logic [DATA_WIDTH-1:0]             rsp_rdata_o,
  output logic                              xfer_valid_o,
  output logic                              xfer_rdwr_o,
  output logic [ADDR_WIDTH-1:0]             xfer_addr_o,
  output logic [DATA_WIDTH-1:0]             xfer_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           xfer_mask_o,
  input  logic                              xfer_done_i,
  input  logic [DATA_WIDTH-1:0]             xfer_rdata_i,
  output logic                              busy_o
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned MSK_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t                  state_q, state_d;
  logic [CH_W-1:0]         rr_ptr_q;
  logic [CH_W-1:0]         ch_q;
  logic                    rdwr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [MSK_W-1:0]        mask_q;
  logic [TMO_WIDTH-1:0]    cnt_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [CH_W-1:0]         win;
  logic [CH_W-1:0]         win_next;
  logic                    win_found;
  logic                    grant;
  logic                    tmo_hit;
  int unsigned             idx;
  logic [CH_W-1:0]         idx_c;

  // Search from rr_ptr (round-robin) or from 0 (fixed), wrapping modulo NUM_CH.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    idx       = 0;
    idx_c     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = cfg_prio_i ? i : (32'(rr_ptr_q) + i);
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_c = CH_W'(idx);
      if (!win_found && req_valid_i[idx_c]) begin
        win       = idx_c;
        win_found = 1'b1;
      end
    end
  end

  assign win_next = (win == CH_W'(NUM_CH - 1)) ? '0 : win + CH_W'(1);
  assign grant    = (state_q == IDLE) && cfg_en_i && win_found;
  assign tmo_hit  = (cfg_tmo_i != '0) && (cnt_q == cfg_tmo_i - TMO_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = XFER;
      XFER:    if (xfer_done_i || tmo_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      req_ready_o[k] = grant && (win == CH_W'(k));
      rsp_valid_o[k] = (state_q == RESP) && (ch_q == CH_W'(k));
    end
  end

  assign rsp_err_o    = (state_q == RESP) && err_q;
  assign rsp_rdata_o  = (state_q == RESP) ? rdata_q : '0;
  assign xfer_valid_o = (state_q == XFER);
  assign xfer_rdwr_o  = rdwr_q;
  assign xfer_addr_o  = addr_q;
  assign xfer_wdata_o = wdata_q;
  assign xfer_mask_o  = mask_q;
  assign busy_o       = (state_q != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      ch_q     <= '0;
      rdwr_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      cnt_q <= (state_q == XFER) ? cnt_q + TMO_WIDTH'(1) : '0;
      if (grant) begin
        ch_q    <= win;
        rdwr_q  <= req_rdwr_i[win];
        addr_q  <= req_addr_i[32'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_q <= req_wdata_i[32'(win)*DATA_WIDTH +: DATA_WIDTH];
        mask_q  <= req_mask_i[32'(win)*MSK_W +: MSK_W];
        if (!cfg_prio_i) rr_ptr_q <= win_next;
      end
      // Completion takes precedence over a timeout landing on the same cycle.
      if (state_q == XFER) begin
        if (xfer_done_i) begin
          err_q   <= 1'b0;
          rdata_q <= rdwr_q ? xfer_rdata_i : '0;
        end else if (tmo_hit) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_psram_xfer_arb.sv
// Directed self-checking bench for psram_xfer_arb (4 channels, 32-bit address, 64-bit data).
module tb_psram_xfer_arb;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cfg_en_i, cfg_prio_i;
  logic [15:0]  cfg_tmo_i;
  logic [3:0]   req_valid_i, req_ready_o, req_rdwr_i, rsp_valid_o;
  logic [127:0] req_addr_i;
  logic [255:0] req_wdata_i;
  logic [31:0]  req_mask_i;
  logic         rsp_err_o, xfer_valid_o, xfer_rdwr_o, xfer_done_i, busy_o;
  logic [63:0]  rsp_rdata_o, xfer_wdata_o, xfer_rdata_i;
  logic [31:0]  xfer_addr_o;
  logic [7:0]   xfer_mask_o;

  logic [31:0]  ch_addr  [4];
  logic [63:0]  ch_wdata [4];
  logic [7:0]   ch_mask  [4];
  logic         ch_rd    [4];

  int errors = 0;
  int checks = 0;

  psram_xfer_arb #(.NUM_CH(4), .ADDR_WIDTH(32), .DATA_WIDTH(64), .TMO_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_en_i(cfg_en_i), .cfg_prio_i(cfg_prio_i),
    .cfg_tmo_i(cfg_tmo_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rdwr_i(req_rdwr_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_mask_i(req_mask_i), .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o),
    .rsp_rdata_o(rsp_rdata_o), .xfer_valid_o(xfer_valid_o), .xfer_rdwr_o(xfer_rdwr_o),
    .xfer_addr_o(xfer_addr_o), .xfer_wdata_o(xfer_wdata_o), .xfer_mask_o(xfer_mask_o),
    .xfer_done_i(xfer_done_i), .xfer_rdata_i(xfer_rdata_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_ch(input int k, input logic rd, input logic [31:0] a,
                        input logic [63:0] wd, input logic [7:0] m);
    ch_rd[k]    = rd;
    ch_addr[k]  = a;
    ch_wdata[k] = wd;
    ch_mask[k]  = m;
    req_rdwr_i[k]            = rd;
    req_addr_i[k*32 +: 32]   = a;
    req_wdata_i[k*64 +: 64]  = wd;
    req_mask_i[k*8 +: 8]     = m;
  endtask

  // Called in IDLE with requests already driven; expects channel ch to win.
  task automatic serve(input string tag, input int ch, input int wait_cyc,
                       input logic [63:0] rd, input logic drop);
    logic [3:0] gnt;
    gnt = 4'b0001 << ch;
    #1;
    check({tag, " ready"}, 64'(req_ready_o), 64'(gnt));
    check({tag, " idle"}, 64'(busy_o), 64'd0);
    tick();
    if (drop) req_valid_i = req_valid_i & ~gnt;
    #1;
    check({tag, " xvalid"}, 64'(xfer_valid_o), 64'd1);
    check({tag, " xaddr"}, 64'(xfer_addr_o), 64'(ch_addr[ch]));
    check({tag, " xrdwr"}, 64'(xfer_rdwr_o), 64'(ch_rd[ch]));
    check({tag, " xwdata"}, xfer_wdata_o, ch_wdata[ch]);
    check({tag, " xmask"}, 64'(xfer_mask_o), 64'(ch_mask[ch]));
    for (int c = 1; c < wait_cyc; c++) tick();
    check({tag, " hold"}, 64'(xfer_valid_o), 64'd1);
    xfer_done_i  = 1'b1;
    xfer_rdata_i = rd;
    tick();
    xfer_done_i  = 1'b0;
    xfer_rdata_i = 64'h5555_5555_5555_5555;
    #1;
    check({tag, " rvalid"}, 64'(rsp_valid_o), 64'(gnt));
    check({tag, " rerr"}, 64'(rsp_err_o), 64'd0);
    check({tag, " rdata"}, rsp_rdata_o, ch_rd[ch] ? rd : 64'd0);
    check({tag, " xdrop"}, 64'(xfer_valid_o), 64'd0);
    tick();
    check({tag, " rpulse"}, 64'(rsp_valid_o), 64'd0);
    check({tag, " rdata0"}, rsp_rdata_o, 64'd0);
  endtask

  initial begin
    int n;
    logic [3:0] seen;
    int exp_order[5];
    rst_i = 1'b1;
    cfg_en_i = 1'b1; cfg_prio_i = 1'b0; cfg_tmo_i = '0;
    req_valid_i = '0; req_rdwr_i = '0; req_addr_i = '0; req_wdata_i = '0; req_mask_i = '0;
    xfer_done_i = 1'b0; xfer_rdata_i = '0;
    for (int k = 0; k < 4; k++)
      set_ch(k, k[0], 32'h1000 + 32'(k) * 32'h10, 64'h0102_0304_0506_0700 + 64'(k), 8'hF0 | 8'(k));
    #2;
    check("rst busy", 64'(busy_o), 64'd0);
    check("rst xvalid", 64'(xfer_valid_o), 64'd0);
    check("rst rvalid", 64'(rsp_valid_o), 64'd0);
    check("rst xaddr", 64'(xfer_addr_o), 64'd0);
    check("rst xmask", 64'(xfer_mask_o), 64'd0);
    check("rst rdata", rsp_rdata_o, 64'd0);
    repeat (2) tick();
    rst_i = 1'b0;
    tick();

    // Round-robin with all channels continuously valid.
    exp_order = '{0, 1, 2, 3, 0};
    req_valid_i = 4'b1111;
    for (int t = 0; t < 5; t++)
      serve("rr", exp_order[t], 2, 64'hA0A0_0000_0000_0000 + 64'(t), 1'b0);
    req_valid_i = '0;

    // Single read on ch1, core answers after 5 cycles.
    set_ch(1, 1'b1, 32'h100, 64'h0, 8'hFF);
    req_valid_i = 4'b0010;
    serve("ch1rd", 1, 5, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);

    // Fixed priority: ch0 wins every time against ch3; pointer must not move.
    cfg_prio_i = 1'b1;
    req_valid_i = 4'b1001;
    for (int t = 0; t < 3; t++) serve("fix", 0, 2, 64'h1234, 1'b0);
    cfg_prio_i = 1'b0;
    req_valid_i = 4'b1111;
    serve("rrptr", 2, 2, 64'h77, 1'b0);
    req_valid_i = '0;

    // Timeout of 8 cycles on a ch2 write.
    cfg_tmo_i = 16'd8;
    req_valid_i = 4'b0100;
    #1;
    check("tmo ready", 64'(req_ready_o), 64'b0100);
    tick();
    req_valid_i = '0;
    n = 0;
    while (xfer_valid_o && n < 20) begin
      n++;
      tick();
    end
    check("tmo cycles", 64'(n), 64'd8);
    check("tmo rvalid", 64'(rsp_valid_o), 64'b0100);
    check("tmo err", 64'(rsp_err_o), 64'd1);
    check("tmo rdata", rsp_rdata_o, 64'd0);
    tick();
    check("tmo err0", 64'(rsp_err_o), 64'd0);

    // Timeout disabled: transaction waits 40 cycles.
    cfg_tmo_i = '0;
    req_valid_i = 4'b0001;
    serve("notmo", 0, 40, 64'h99, 1'b1);

    // Done on the same cycle the timeout would fire.
    cfg_tmo_i = 16'd4;
    set_ch(3, 1'b1, 32'h300, 64'h0, 8'hFF);
    req_valid_i = 4'b1000;
    serve("coinc", 3, 4, 64'h0BAD_CAFE_1234_5678, 1'b1);
    cfg_tmo_i = '0;

    // Arbitration disabled; stray done in IDLE is ignored.
    cfg_en_i = 1'b0;
    req_valid_i = 4'b1111;
    xfer_done_i = 1'b1;
    #1;
    check("dis ready", 64'(req_ready_o), 64'd0);
    check("dis busy", 64'(busy_o), 64'd0);
    tick();
    xfer_done_i = 1'b0;
    check("dis busy2", 64'(busy_o), 64'd0);
    check("dis rvalid", 64'(rsp_valid_o), 64'd0);
    req_valid_i = '0;
    cfg_en_i = 1'b1;
    set_ch(0, 1'b0, 32'h40, 64'h1122_3344_5566_7788, 8'h0F);
    req_valid_i = 4'b0001;
    serve("wr0", 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    // Reset in the middle of a transaction.
    req_valid_i = 4'b0010;
    tick();
    req_valid_i = '0;
    tick();
    check("mid xvalid", 64'(xfer_valid_o), 64'd1);
    rst_i = 1'b1;
    xfer_done_i = 1'b1;
    #1;
    check("mid rst xvalid", 64'(xfer_valid_o), 64'd0);
    check("mid rst busy", 64'(busy_o), 64'd0);
    check("mid rst xaddr", 64'(xfer_addr_o), 64'd0);
    seen = rsp_valid_o;
    tick();
    seen |= rsp_valid_o;
    rst_i = 1'b0;
    tick();
    xfer_done_i = 1'b0;
    for (int t = 0; t < 3; t++) begin
      seen |= rsp_valid_o;
      tick();
    end
    check("mid no rsp", 64'(seen), 64'd0);
    req_valid_i = 4'b0100;
    serve("post ch2", 2, 2, 64'h42, 1'b1);
    req_valid_i = 4'b1111;
    serve("post ptr3", 3, 2, 64'h43, 1'b0);
    req_valid_i = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
